// File: rtl/quad_decoder.sv
// x4 quadrature decoder: sync, glitch filter, Gray decode, position count.
// Optional clamping of position at limits when QUAD_CLAMP_EN is defined.
module quad_decoder #(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned POS_WIDTH  = 8,
  parameter logic [POS_WIDTH-1:0] POS_INIT = 8'h80,
  parameter logic [POS_WIDTH-1:0] POS_MIN  = 8'h00,
  parameter logic [POS_WIDTH-1:0] POS_MAX  = 8'hFF
) (
  input  logic                 clk_sys,
  input  logic                 Reset_n,
  input  logic                 enc_a,
  input  logic                 enc_b,
  input  logic                 clear,
  output logic [POS_WIDTH-1:0] position,
  output logic                 step,
  output logic                 dir,
  output logic                 err,
  output logic                 sat
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN);

  if (FILTER_LEN < 1) begin : g_bad_filter
    $error("FILTER_LEN must be at least 1");
  end
  if (POS_MIN > POS_MAX) begin : g_bad_limits
    $error("POS_MIN above POS_MAX");
  end

  logic [1:0]           sync1_q, sync1_d;
  logic [1:0]           sync2_q, sync2_d;
  logic [1:0]           sprev_q, sprev_d;
  logic [1:0]           prev_q, prev_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 primed_q, primed_d;
  logic                 step_q, step_d;
  logic                 dir_q, dir_d;
  logic                 err_q, err_d;
  logic                 sat_q, sat_d;
  logic [POS_WIDTH-1:0] pos_q, pos_d;
  logic                 accept;
  logic                 fwd;
  logic                 bwd;
  logic                 both;

  // Successor of a state in the +1 Gray sequence 00-01-11-10
  function automatic logic [1:0] gnext(input logic [1:0] v);
    logic [1:0] r;
    r = 2'b00;
    case (v)
      2'b00:   r = 2'b01;
      2'b01:   r = 2'b11;
      2'b11:   r = 2'b10;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // Synchronizer chain and stability counter; accept once per stable run
  always_comb begin
    sync1_d = {enc_a, enc_b};
    sync2_d = sync1_q;
    sprev_d = sync2_q;
    cnt_d   = cnt_q;
    if (sync2_q != sprev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    accept = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
  end

  // Classify accepted sample against the last accepted one
  always_comb begin
    fwd      = accept && primed_q && (sync2_q == gnext(prev_q));
    bwd      = accept && primed_q && (prev_q == gnext(sync2_q));
    both     = accept && primed_q && ((sync2_q ^ prev_q) == 2'b11);
    prev_d   = accept ? sync2_q : prev_q;
    primed_d = primed_q | accept;
    step_d   = fwd | bwd;
    err_d    = both;
    dir_d    = dir_q;
    if (fwd) begin
      dir_d = 1'b1;
    end else if (bwd) begin
      dir_d = 1'b0;
    end
  end

  // Position update; clear overrides a coincident step
  always_comb begin
    pos_d = pos_q;
    sat_d = 1'b0;
`ifdef QUAD_CLAMP_EN
    if (clear) begin
      pos_d = POS_INIT;
    end else if (fwd && (pos_q != POS_MAX)) begin
      pos_d = pos_q + 1'b1;
    end else if (bwd && (pos_q != POS_MIN)) begin
      pos_d = pos_q - 1'b1;
    end
    sat_d = !clear && ((pos_d == POS_MIN) || (pos_d == POS_MAX));
`else
    if (clear) begin
      pos_d = POS_INIT;
    end else if (fwd) begin
      pos_d = pos_q + 1'b1;
    end else if (bwd) begin
      pos_d = pos_q - 1'b1;
    end
`endif
  end

  // State registers
  always_ff @(posedge clk_sys or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q  <= 2'b00;
      sync2_q  <= 2'b00;
      sprev_q  <= 2'b00;
      prev_q   <= 2'b00;
      cnt_q    <= '0;
      primed_q <= 1'b0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
      sat_q    <= 1'b0;
      pos_q    <= POS_INIT;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      sprev_q  <= sprev_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      sat_q    <= sat_d;
      pos_q    <= pos_d;
    end
  end

  assign position = pos_q;
  assign step     = step_q;
  assign dir      = dir_q;
  assign err      = err_q;
  assign sat      = sat_q;

endmodule
